// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin arbitration,
// a single-entry registered output stage and a saturating output beat counter.
//
// Handshake: a beat moves on a port at a rising clk edge where valid && ready.
// Senders hold valid/data until taken. in_ready depends only on control signals
// (out_valid, out_ready, in_valid, sel, ptr), never on in_data.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_idx,
    output logic [15:0]          out_beats
);

    logic             load;
    logic             found;
    logic [SW-1:0]    choice;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    ptr_next;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] choice_data;

    assign load     = !out_valid || out_ready;
    assign out_xfer = out_valid && out_ready;

    // Round-robin: scan downward so the last hit written is the first valid at or after ptr.
    always_comb begin
        found  = 1'b0;
        choice = '0;
        if (MODE == 0) begin
            if (int'(sel) < N) begin
                found  = 1'b1;
                choice = sel;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[(int'(ptr) + i) % N]) begin
                    found  = 1'b1;
                    choice = SW'((int'(ptr) + i) % N);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load && found) begin
            in_ready[choice] = 1'b1;
        end
    end

    assign in_xfer     = |(in_ready & in_valid);
    assign choice_data = in_data[int'(choice) * WIDTH +: WIDTH];
    assign ptr_next    = (choice == SW'(N - 1)) ? '0 : choice + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            ptr       <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= choice_data;
            out_idx   <= choice;
            if (MODE != 0) begin
                ptr <= ptr_next;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_beats <= '0;
        end else if (out_xfer && out_beats != 16'hFFFF) begin
            out_beats <= out_beats + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: a round-robin instance (N=4) and a
// fixed-select instance (N=3, so an out-of-range select exists) against a behavioural model.
module tb_stream_mux_rr;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NF = 3;
  localparam int SW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_idx;
  logic [15:0]    out_beats;

  stream_mux_rr #(.WIDTH(W), .N(N), .MODE(1), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_beats(out_beats)
  );

  // fixed-select instance
  logic [NF*W-1:0] f_in_data;
  logic [NF-1:0]   f_in_valid;
  logic [NF-1:0]   f_in_ready;
  logic [SW-1:0]   f_sel;
  logic [W-1:0]    f_out_data;
  logic            f_out_valid;
  logic            f_out_ready;
  logic [SW-1:0]   f_out_idx;
  logic [15:0]     f_out_beats;

  stream_mux_rr #(.WIDTH(W), .N(NF), .MODE(0), .SW(SW)) dut_fix (
    .clk(clk), .rst_n(rst_n), .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .sel(f_sel), .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_idx(f_out_idx), .out_beats(f_out_beats)
  );

  // scoreboard / counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: output register contents, pointer, beat count, accepted-beat queue
  int             m_ptr;
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic [SW-1:0]  m_idx;
  int             m_beats;
  logic [W+SW-1:0] exp_q[$];
  logic           fm_valid;
  logic [W-1:0]   fm_data;
  logic [SW-1:0]  fm_idx;
  int             fm_beats;

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_idx = '0; m_beats = 0;
    exp_q.delete();
    fm_valid = 1'b0; fm_data = '0; fm_idx = '0; fm_beats = 0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // driver: one cycle on the round-robin instance, called and returning at a negedge
  task automatic step(input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d);
    int k;
    logic [N-1:0] er;
    logic oxfer;
    in_valid = v; out_ready = ordy; in_data = d;
    #1;
    k  = (m_valid && !ordy) ? -1 : rr_pick(v, m_ptr);
    er = (k < 0) ? '0 : (N'(1) << k);
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_idx", out_idx, m_idx);
    check("out_beats", out_beats, m_beats);
    oxfer = m_valid && ordy;
    if (oxfer) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_beat", {out_idx, out_data}, exp_q.pop_front());
      if (m_beats < 65535) m_beats++;
    end
    if (k >= 0) begin
      m_valid = 1'b1;
      m_data  = d[k*W +: W];
      m_idx   = SW'(k);
      m_ptr   = (k + 1) % N;
      exp_q.push_back({SW'(k), d[k*W +: W]});
    end else if (oxfer) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: one cycle on the fixed-select instance
  task automatic fstep(input logic [SW-1:0] s, input logic [NF-1:0] v, input logic ordy,
                       input logic [NF*W-1:0] d);
    logic [NF-1:0] er;
    f_sel = s; f_in_valid = v; f_out_ready = ordy; f_in_data = d;
    #1;
    er = ((!fm_valid || ordy) && int'(s) < NF) ? (NF'(1) << s) : '0;
    check("f_in_ready", f_in_ready, er);
    check("f_out_valid", f_out_valid, fm_valid);
    check("f_out_data", f_out_data, fm_data);
    check("f_out_idx", f_out_idx, fm_idx);
    check("f_out_beats", f_out_beats, fm_beats);
    if (fm_valid && ordy && fm_beats < 65535) fm_beats++;
    if ((er & v) != '0) begin
      fm_valid = 1'b1;
      fm_data  = d[int'(s)*W +: W];
      fm_idx   = s;
    end else if (fm_valid && ordy) begin
      fm_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // asynchronous reset from a negedge; outputs must clear before any clock edge
  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = '1; out_ready = 1'b1; f_in_valid = '1; f_out_ready = 1'b1; f_sel = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_f_in_ready", f_in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_in_ready", in_ready, 0);
    rst_n = 1'b1;
    in_valid = '0; f_in_valid = '0;
    model_reset();
  endtask

  int seq_idx[5] = '{0, 1, 2, 3, 0};
  int sparse[3]  = '{1, 3, 1};

  initial begin
    in_data = '0; in_valid = '0; out_ready = 1'b0; sel = '0;
    f_in_data = '0; f_in_valid = '0; f_out_ready = 1'b0; f_sel = '0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // all channels valid: strict rotation, one beat per cycle
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b1, 32'hA3A2A1A0);
      check("rr_seq_idx", out_idx, seq_idx[i]);
      check("rr_seq_valid", out_valid, 1);
    end

    // sparse valids from ptr=0
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 1'b1, $urandom);
      check("rr_sparse_idx", out_idx, sparse[i]);
    end

    // backpressure with a held beat
    step(4'b0001, 1'b1, 32'h0000005A);
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b0, $urandom);
      check("stall_data", out_data, 8'h5A);
    end
    step(4'h0, 1'b1, $urandom);
    check("stall_drained", out_valid, 0);
    step(4'hF, 1'b1, $urandom);
    check("stall_ptr_kept", out_idx, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom);
    end

    // reset mid-stream with a held beat
    step(4'hF, 1'b0, $urandom);
    check("pre_rst_valid", out_valid, 1);
    apply_reset();
    step(4'hF, 1'b1, $urandom);
    check("post_rst_grant", out_idx, 0);

    // counter saturation
    step(4'h0, 1'b1, $urandom);
    step(4'h0, 1'b1, $urandom);
    force dut.out_beats = 16'hFFFE;
    #1;
    release dut.out_beats;
    m_beats = 65534;
    for (int i = 0; i < 6; i++) step(4'hF, 1'b1, $urandom);
    check("beats_saturated", out_beats, 16'hFFFF);

    // fixed-select instance
    apply_reset();
    fstep(2'd2, 3'b001, 1'b1, 24'($urandom));
    check("fix_no_xfer", f_out_valid, 0);
    fstep(2'd2, 3'b100, 1'b1, 24'h3C0000);
    check("fix_data", f_out_data, 8'h3C);
    check("fix_idx", f_out_idx, 2);
    fstep(2'd3, 3'b111, 1'b1, 24'($urandom));
    check("fix_sel_oor", f_out_valid, 0);
    for (int i = 0; i < 150; i++) begin
      fstep(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
